// File: rtl/chrono_pkg.sv
// Shared definitions for the stopwatch controller.
//   DEPTH_DEF : default number of lap/record slots
//   AW_DEF    : default register-file address width
//   state_t   : controller FSM state encoding
package chrono_pkg;

    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned AW_DEF    = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2,
        StStopped = 2'd3
    } state_t;

endpackage

// File: rtl/btn_edge.sv
// One-bit rising-edge detector for a debounced button level.
//   clk     : system clock
//   reset   : synchronous, active-high reset (clears the history bit)
//   i_level : debounced button level
//   o_edge  : high for the single cycle where the level rises
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_edge = i_level & ~r_prev;

endmodule

// File: rtl/chrono_ctrl.sv
// Stopwatch controller: button edge detection, run/pause/stop FSM, lap recording
// into an external register file and recall address selection.
//   clk, reset          : clock, synchronous active-high reset
//   btn_start_stop      : start/stop request (level)
//   btn_pause           : pause/resume request (level)
//   btn_lap             : record lap, or step recall pointer when stopped (level)
//   recall_mode         : 1 = read address comes from reg_address
//   reg_address         : user-selected recall slot
//   run_en              : timer count enable
//   timer_clear         : one-cycle timer clear pulse
//   rf_we/rf_waddr      : register-file write strobe and address
//   rf_raddr            : register-file read address
//   show_live           : 1 = display live timer, 0 = display recalled slot
//   lap_count           : slots written since last start
//   full                : lap_count == DEPTH
//   addr_exceed         : recall_mode and reg_address >= lap_count
module chrono_ctrl
    import chrono_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_start_stop,
    input  logic          btn_pause,
    input  logic          btn_lap,
    input  logic          recall_mode,
    input  logic [AW-1:0] reg_address,
    output logic          run_en,
    output logic          timer_clear,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [AW-1:0] rf_raddr,
    output logic          show_live,
    output logic [AW:0]   lap_count,
    output logic          full,
    output logic          addr_exceed
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic w_edge_ss;
    logic w_edge_pa;
    logic w_edge_lp;
    logic w_ev_ss;
    logic w_ev_pa;
    logic w_ev_lp;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW:0]   r_lap_count;
    logic [AW:0]   w_lap_count_next;
    logic [AW-1:0] r_disp_ptr;
    logic [AW-1:0] w_disp_ptr_next;
    logic          w_timer_clear;
    logic          w_record;
    logic          w_write;
    logic          w_full;

    btn_edge u_edge_ss (
        .clk     (clk),
        .reset   (reset),
        .i_level (btn_start_stop),
        .o_edge  (w_edge_ss)
    );

    btn_edge u_edge_pa (
        .clk     (clk),
        .reset   (reset),
        .i_level (btn_pause),
        .o_edge  (w_edge_pa)
    );

    btn_edge u_edge_lp (
        .clk     (clk),
        .reset   (reset),
        .i_level (btn_lap),
        .o_edge  (w_edge_lp)
    );

    // Priority start_stop > pause > lap; lower-priority edges in the same cycle are dropped.
    // Events are masked during reset so no strobe escapes while the FSM is being cleared.
    assign w_ev_ss = w_edge_ss & ~reset;
    assign w_ev_pa = w_edge_pa & ~w_edge_ss & ~reset;
    assign w_ev_lp = w_edge_lp & ~w_edge_ss & ~w_edge_pa & ~reset;

    assign w_full = (r_lap_count == DEPTH_CNT);

    always_comb begin
        w_state_next     = r_state;
        w_lap_count_next = r_lap_count;
        w_disp_ptr_next  = r_disp_ptr;
        w_timer_clear    = 1'b0;
        w_record         = 1'b0;

        unique case (r_state)
            StIdle, StStopped: begin
                if (w_ev_ss) begin
                    // Clear is issued now; run_en only starts once the state is RUNNING.
                    w_timer_clear    = 1'b1;
                    w_state_next     = StRunning;
                    w_lap_count_next = '0;
                    w_disp_ptr_next  = '0;
                end else if (w_ev_lp && (r_state == StStopped) && (r_lap_count != '0)) begin
                    if ({1'b0, r_disp_ptr} == (r_lap_count - CNT_ONE)) begin
                        w_disp_ptr_next = '0;
                    end else begin
                        w_disp_ptr_next = r_disp_ptr + PTR_ONE;
                    end
                end
            end
            StRunning, StPaused: begin
                if (w_ev_ss) begin
                    w_record     = 1'b1;
                    w_state_next = StStopped;
                end else if (w_ev_pa) begin
                    w_state_next = (r_state == StRunning) ? StPaused : StRunning;
                end else if (w_ev_lp) begin
                    w_record = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // A record request on a full file is silently discarded.
        w_write = w_record & ~w_full;
        if (w_write) begin
            w_lap_count_next = r_lap_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_lap_count <= '0;
            r_disp_ptr  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_lap_count <= w_lap_count_next;
            r_disp_ptr  <= w_disp_ptr_next;
        end
    end

    assign run_en      = (r_state == StRunning);
    assign show_live   = (r_state == StRunning) || (r_state == StPaused);
    assign timer_clear = w_timer_clear;
    assign rf_we       = w_write;
    assign rf_waddr    = r_lap_count[AW-1:0];
    assign rf_raddr    = recall_mode ? reg_address : r_disp_ptr;
    assign lap_count   = r_lap_count;
    assign full        = w_full;
    assign addr_exceed = recall_mode & ({1'b0, reg_address} >= r_lap_count);

endmodule

// File: tb/tb_chrono_ctrl.sv
// Self-checking bench for chrono_ctrl: directed scenarios followed by random button
// traffic, all compared every cycle against a behavioural stopwatch model.
module tb_chrono_ctrl;

    localparam int D = 16;
    localparam int A = 4;

    // Model modes
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_STOP  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         ss;
    logic         pa;
    logic         lp;
    logic         rm;
    logic [A-1:0] ra;
    logic         run_en;
    logic         timer_clear;
    logic         rf_we;
    logic [A-1:0] rf_waddr;
    logic [A-1:0] rf_raddr;
    logic         show_live;
    logic [A:0]   lap_count;
    logic         full;
    logic         addr_exceed;

    chrono_ctrl #(
        .DEPTH (D),
        .AW    (A)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (ss),
        .btn_pause      (pa),
        .btn_lap        (lp),
        .recall_mode    (rm),
        .reg_address    (ra),
        .run_en         (run_en),
        .timer_clear    (timer_clear),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_raddr       (rf_raddr),
        .show_live      (show_live),
        .lap_count      (lap_count),
        .full           (full),
        .addr_exceed    (addr_exceed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_mode = M_IDLE;
    int m_cnt  = 0;
    int m_ptr  = 0;
    bit m_pss  = 1'b0;
    bit m_ppa  = 1'b0;
    bit m_plp  = 1'b0;
    int n_we   = 0;
    bit cur_rm = 1'b0;
    int cur_ra = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply levels, check outputs at negedge against the model,
    // then advance the model at the rising edge.
    task automatic cyc(input bit s, input bit p, input bit l, input bit r);
        bit es, ep, el, active, we;
        ss = s; pa = p; lp = l; reset = r; rm = cur_rm; ra = cur_ra[A-1:0];
        @(negedge clk);
        es     = s & ~m_pss;
        ep     = p & ~m_ppa & ~es;
        el     = l & ~m_plp & ~es & ~(p & ~m_ppa);
        active = (m_mode == M_RUN) || (m_mode == M_PAUSE);
        we     = active && (es || el) && (m_cnt < D);
        if (!r) begin
            check("timer_clear", timer_clear, es && !active);
            check("rf_we", rf_we, we);
            if (we) check("rf_waddr", rf_waddr, m_cnt);
            check("run_en", run_en, m_mode == M_RUN);
            check("show_live", show_live, active);
            check("lap_count", lap_count, m_cnt);
            check("full", full, m_cnt == D);
            check("addr_exceed", addr_exceed, cur_rm && (cur_ra >= m_cnt));
            check("rf_raddr", rf_raddr, cur_rm ? cur_ra : m_ptr);
        end
        if (rf_we === 1'b1) n_we++;
        @(posedge clk);
        if (r) begin
            m_mode = M_IDLE; m_cnt = 0; m_ptr = 0;
            m_pss = 1'b0; m_ppa = 1'b0; m_plp = 1'b0;
        end else begin
            if (es && !active) begin
                m_mode = M_RUN; m_cnt = 0; m_ptr = 0;
            end else if (es) begin
                if (m_cnt < D) m_cnt++;
                m_mode = M_STOP;
            end else if (ep) begin
                if (m_mode == M_RUN) m_mode = M_PAUSE;
                else if (m_mode == M_PAUSE) m_mode = M_RUN;
            end else if (el) begin
                if (active) begin
                    if (m_cnt < D) m_cnt++;
                end else if (m_mode == M_STOP && m_cnt > 0) begin
                    m_ptr = (m_ptr + 1) % m_cnt;
                end
            end
            m_pss = s; m_ppa = p; m_plp = l;
        end
        #1;
    endtask

    task automatic press_ss();  cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); endtask
    task automatic press_lap(); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); endtask

    initial begin
        int exp_ptr[4];
        exp_ptr = '{1, 2, 0, 1};

        // Reset
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check("rst_lap_count", lap_count, 0);
        check("rst_run_en", run_en, 0);

        // Start: clear pulse then run
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("start_run_en", run_en, 1);

        // Three laps then stop: four writes
        n_we = 0;
        press_lap(); press_lap(); press_lap();
        press_ss();
        check("stop_writes", n_we, 4);
        check("stop_lap_count", lap_count, 4);
        check("stop_show_live", show_live, 0);

        // Overfill: 17 lap edges yield 16 writes
        press_ss();
        n_we = 0;
        for (int i = 0; i < 17; i++) press_lap();
        check("full_writes", n_we, 16);
        check("full_flag", full, 1);
        press_ss();
        check("full_stop_writes", n_we, 16);

        // Recall pointer stepping with three slots
        press_ss();
        press_lap(); press_lap();
        press_ss();
        check("recall_lap_count", lap_count, 3);
        for (int i = 0; i < 4; i++) begin
            press_lap();
            check("recall_ptr", rf_raddr, exp_ptr[i]);
        end

        // User recall address range
        cur_rm = 1'b1; cur_ra = 5;
        cyc(0, 0, 0, 0);
        check("exceed_hi", addr_exceed, 1);
        check("raddr_user", rf_raddr, 5);
        cur_ra = 2;
        cyc(0, 0, 0, 0);
        check("exceed_lo", addr_exceed, 0);
        cur_rm = 1'b0; cur_ra = 0;

        // Simultaneous stop and lap: one write only
        press_ss();
        n_we = 0;
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("simul_writes", n_we, 1);
        check("simul_stopped", show_live, 0);

        // Pause held for ten cycles toggles once
        press_ss();
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        check("pause_run_en", run_en, 0);
        check("pause_show_live", show_live, 1);
        cyc(0, 0, 0, 0);

        // Reset while running
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check("rst_mid_run_en", run_en, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cur_rm = ($urandom_range(0, 3) == 0);
            cur_ra = $urandom_range(0, 15);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
